// File: rtl/nano_cache_miss_ctrl.sv
// nano_cache_miss_ctrl
// Miss sequencer between tag lookup and the cache update stage. It takes one
// miss at a time, writes back a dirty victim line, issues the refill read,
// waits (with a watchdog) for the refilled 8-word line and presents it to the
// tag/data arrays as a single-cycle fill. A pipeline flush aborts the miss.
module nano_cache_miss_ctrl #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_flush,
   input  logic         i_req_valid,
   output logic         o_req_ready,
   input  logic [31:0]  i_req_addr,
   input  logic         i_req_victim_dirty,
   input  logic [31:0]  i_req_victim_addr,
   input  logic [255:0] i_req_victim_data,
   output logic         o_miss_rden,
   output logic         o_miss_wren,
   output logic [31:0]  o_miss_addr,
   output logic [255:0] o_miss_wdata,
   output logic [31:0]  o_miss_wstrb,
   input  logic         i_miss_resp,
   input  logic         i_upd_valid,
   input  logic [255:0] i_upd_rdata,
   output logic         o_fill_valid,
   output logic [31:0]  o_fill_addr,
   output logic [255:0] o_fill_data,
   output logic         o_busy,
   output logic         o_err
);

   localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_MAX);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WB   = 3'd1,
      RD   = 3'd2,
      WAIT = 3'd3,
      FILL = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
   logic [31:0]        reqAddr_q;
   logic [31:0]        vicAddr_q;
   logic [255:0]       vicData_q;
   logic [255:0]       fillData_q;
   logic               accept;
   logic               latchFill;
   logic               timeout;

   // Byte offsets inside a line never matter: everything is line-aligned.
   logic unusedBits;
   assign unusedBits = &{1'b0, i_req_addr[4:0], i_req_victim_addr[4:0]};

   // State register and watchdog counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Miss fields are captured at accept, refill data when it arrives in WAIT.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         reqAddr_q  <= '0;
         vicAddr_q  <= '0;
         vicData_q  <= '0;
         fillData_q <= '0;
      end else begin
         if (accept) begin
            reqAddr_q <= {i_req_addr[31:5], 5'b0};
            vicAddr_q <= {i_req_victim_addr[31:5], 5'b0};
            vicData_q <= i_req_victim_data;
         end
         if (latchFill) begin
            fillData_q <= i_upd_rdata;
         end
      end
   end

   // Next-state logic; a flush overrides everything and returns to IDLE.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      accept    = 1'b0;
      latchFill = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req_valid && !i_flush) begin
               accept  = 1'b1;
               state_d = i_req_victim_dirty ? WB : RD;
            end
         end
         WB: begin
            if (i_miss_resp) begin
               state_d = RD;
            end
         end
         RD: begin
            if (i_miss_resp) begin
               state_d   = WAIT;
               waitCnt_d = '0;
            end
         end
         WAIT: begin
            if (i_upd_valid) begin
               latchFill = 1'b1;
               state_d   = FILL;
            end else if (waitCnt_q == CNT_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end else if (waitCnt_q != CNT_MAX) begin
               waitCnt_d = waitCnt_q + CNT_W'(1);
            end
         end
         FILL: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (i_flush) begin
         state_d   = IDLE;
         latchFill = 1'b0;
         timeout   = 1'b0;
      end
   end

   // Requests and strobes follow the state; fill and error are suppressed by flush.
   always_comb begin
      o_req_ready  = (state_q == IDLE) && !i_flush;
      o_busy       = (state_q != IDLE);
      o_miss_wren  = (state_q == WB);
      o_miss_rden  = (state_q == RD);
      o_miss_addr  = '0;
      o_miss_wdata = '0;
      o_miss_wstrb = '0;
      if (state_q == WB) begin
         o_miss_addr  = vicAddr_q;
         o_miss_wdata = vicData_q;
         o_miss_wstrb = '1;
      end else if (state_q == RD) begin
         o_miss_addr  = reqAddr_q;
      end
      o_fill_valid = (state_q == FILL) && !i_flush;
      o_fill_addr  = reqAddr_q;
      o_fill_data  = fillData_q;
      o_err        = timeout;
   end

endmodule

// File: tb/tb_nano_cache_miss_ctrl.sv
// tb_nano_cache_miss_ctrl
// Directed scenarios with literal expectations followed by random traffic,
// all cross-checked every cycle against a transaction-level model of a miss.
module tb_nano_cache_miss_ctrl;

   localparam int WAIT_MAX = 4;

   logic         clk = 1'b0;
   logic         rstN;
   logic         flush;
   logic         reqValid;
   logic         reqReady;
   logic [31:0]  reqAddr;
   logic         vicDirty;
   logic [31:0]  vicAddr;
   logic [255:0] vicData;
   logic         missRden;
   logic         missWren;
   logic [31:0]  missAddr;
   logic [255:0] missWdata;
   logic [31:0]  missWstrb;
   logic         missResp;
   logic         updValid;
   logic [255:0] updRdata;
   logic         fillValid;
   logic [31:0]  fillAddr;
   logic [255:0] fillData;
   logic         busy;
   logic         err;

   int checks = 0;
   int failures = 0;
   int accepts = 0;

   nano_cache_miss_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_flush(flush),
      .i_req_valid(reqValid),
      .o_req_ready(reqReady),
      .i_req_addr(reqAddr),
      .i_req_victim_dirty(vicDirty),
      .i_req_victim_addr(vicAddr),
      .i_req_victim_data(vicData),
      .o_miss_rden(missRden),
      .o_miss_wren(missWren),
      .o_miss_addr(missAddr),
      .o_miss_wdata(missWdata),
      .o_miss_wstrb(missWstrb),
      .i_miss_resp(missResp),
      .i_upd_valid(updValid),
      .i_upd_rdata(updRdata),
      .o_fill_valid(fillValid),
      .o_fill_addr(fillAddr),
      .o_fill_data(fillData),
      .o_busy(busy),
      .o_err(err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] randLine();
      logic [255:0] v;
      for (int w = 0; w < 8; w++) v[32*w +: 32] = $urandom;
      return v;
   endfunction

   task automatic applyStimulus();
      reqValid = 1'($urandom_range(0, 1));
      reqAddr  = $urandom;
      vicDirty = 1'($urandom_range(0, 1));
      vicAddr  = $urandom;
      vicData  = randLine();
      missResp = ($urandom_range(0, 9) < 6);
      updValid = ($urandom_range(0, 9) < 3);
      updRdata = randLine();
      flush    = ($urandom_range(0, 19) == 0);
   endtask

   // Transaction model: one outstanding miss described by what still has to happen.
   bit           mActive;
   bit           mNeedWb;
   bit           mNeedRd;
   bit           mFillDue;
   int           mWaitCycles;
   logic [31:0]  mReqAddr;
   logic [31:0]  mVicAddr;
   logic [255:0] mVicData;
   logic [255:0] mFill;

   always @(negedge clk) begin
      bit eWren, eRden, eWaiting, eFill, eErr;
      if (!rstN) begin
         mActive = 0; mNeedWb = 0; mNeedRd = 0; mFillDue = 0; mWaitCycles = 0;
         mReqAddr = '0; mVicAddr = '0; mVicData = '0; mFill = '0;
      end else begin
         eWren    = mActive && mNeedWb;
         eRden    = mActive && !mNeedWb && mNeedRd;
         eWaiting = mActive && !mNeedWb && !mNeedRd && !mFillDue;
         eFill    = mActive && mFillDue && !flush;
         eErr     = eWaiting && !updValid && !flush && (mWaitCycles == WAIT_MAX - 1);
         checkOutput("m_ready", reqReady, !mActive && !flush);
         checkOutput("m_busy", busy, mActive);
         checkOutput("m_wren", missWren, eWren);
         checkOutput("m_rden", missRden, eRden);
         checkOutput("m_wstrb", missWstrb, eWren ? 32'hFFFF_FFFF : 32'h0);
         if (eWren) begin
            checkOutput("m_wb_addr", missAddr, mVicAddr);
            checkOutput("m_wb_data", missWdata, mVicData);
         end
         if (eRden) checkOutput("m_rd_addr", missAddr, mReqAddr);
         checkOutput("m_fill", fillValid, eFill);
         if (eFill) begin
            checkOutput("m_fill_addr", fillAddr, mReqAddr);
            checkOutput("m_fill_data", fillData, mFill);
         end
         checkOutput("m_err", err, eErr);
         if (reqValid && reqReady) accepts++;
         // advance the model by one cycle
         if (flush) begin
            mActive = 0;
         end else if (!mActive) begin
            if (reqValid) begin
               mActive = 1; mNeedWb = vicDirty; mNeedRd = 1; mFillDue = 0; mWaitCycles = 0;
               mReqAddr = reqAddr & 32'hFFFF_FFE0;
               mVicAddr = vicAddr & 32'hFFFF_FFE0;
               mVicData = vicData;
            end
         end else if (eWren) begin
            if (missResp) mNeedWb = 0;
         end else if (eRden) begin
            if (missResp) begin mNeedRd = 0; mWaitCycles = 0; end
         end else if (eWaiting) begin
            if (updValid) begin mFillDue = 1; mFill = updRdata; end
            else if (mWaitCycles == WAIT_MAX - 1) mActive = 0;
            else mWaitCycles++;
         end else begin
            mActive = 0;
         end
      end
   end

   initial begin
      logic [255:0] patA, patB, words;
      int a0;
      rstN = 0; flush = 0; reqValid = 0; reqAddr = '0; vicDirty = 0; vicAddr = '0;
      vicData = '0; missResp = 0; updValid = 0; updRdata = '0;
      patA = randLine();
      patB = randLine();
      for (int w = 0; w < 8; w++) words[32*w +: 32] = 32'(w);

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready", reqReady, 1'b1);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_rden", missRden, 1'b0);
      checkOutput("rst_wren", missWren, 1'b0);
      checkOutput("rst_addr", missAddr, 32'h0);
      checkOutput("rst_wstrb", missWstrb, 32'h0);
      checkOutput("rst_wdata", missWdata, 256'h0);
      checkOutput("rst_fill", fillValid, 1'b0);
      checkOutput("rst_fill_addr", fillAddr, 32'h0);
      checkOutput("rst_fill_data", fillData, 256'h0);
      checkOutput("rst_err", err, 1'b0);
      step();
      rstN = 1;

      $display("[TB] clean miss");
      step(); reqValid = 1; reqAddr = 32'h0000_1234; vicDirty = 0; missResp = 1;
      @(negedge clk); checkOutput("clean_ready", reqReady, 1'b1);
      step(); reqValid = 0;
      @(negedge clk);
      checkOutput("clean_rden", missRden, 1'b1);
      checkOutput("clean_wren", missWren, 1'b0);
      checkOutput("clean_addr", missAddr, 32'h0000_1220);
      step(); @(negedge clk); checkOutput("clean_wait_fill", fillValid, 1'b0);
      step(); updValid = 1; updRdata = patA;
      @(negedge clk); checkOutput("clean_t3_fill", fillValid, 1'b0);
      step(); updValid = 0; updRdata = '0;
      @(negedge clk);
      checkOutput("clean_fill", fillValid, 1'b1);
      checkOutput("clean_fill_addr", fillAddr, 32'h0000_1220);
      checkOutput("clean_fill_data", fillData, patA);
      step(); @(negedge clk);
      checkOutput("clean_busy_low", busy, 1'b0);

      $display("[TB] dirty miss");
      step(); reqValid = 1; reqAddr = 32'h0000_2468; vicDirty = 1; vicAddr = 32'h0000_8040; vicData = words;
      @(negedge clk);
      step(); reqValid = 0; vicDirty = 0; vicAddr = 32'hDEAD_BEEF; vicData = patA;
      @(negedge clk);
      checkOutput("dirty_wren", missWren, 1'b1);
      checkOutput("dirty_wb_rden", missRden, 1'b0);
      checkOutput("dirty_wstrb", missWstrb, 32'hFFFF_FFFF);
      checkOutput("dirty_wb_addr", missAddr, 32'h0000_8040);
      checkOutput("dirty_wdata", missWdata, words);
      step(); @(negedge clk);
      checkOutput("dirty_rden", missRden, 1'b1);
      checkOutput("dirty_rd_wren", missWren, 1'b0);
      checkOutput("dirty_rd_wstrb", missWstrb, 32'h0);
      checkOutput("dirty_rd_addr", missAddr, 32'h0000_2460);
      step(); updValid = 1; updRdata = patB;
      @(negedge clk);
      step(); updValid = 0;
      @(negedge clk);
      checkOutput("dirty_fill", fillValid, 1'b1);
      checkOutput("dirty_fill_addr", fillAddr, 32'h0000_2460);
      checkOutput("dirty_fill_data", fillData, patB);
      step(); @(negedge clk); checkOutput("dirty_idle", busy, 1'b0);

      $display("[TB] response stall");
      step(); reqValid = 1; reqAddr = 32'h0001_00FF; vicDirty = 1; vicAddr = 32'h0002_0033; vicData = patB; missResp = 0;
      @(negedge clk);
      step(); reqValid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("stall_wren", missWren, 1'b1);
         checkOutput("stall_wb_addr", missAddr, 32'h0002_0020);
         checkOutput("stall_wb_ready", reqReady, 1'b0);
         step();
      end
      missResp = 1;
      @(negedge clk); checkOutput("stall_wren_hs", missWren, 1'b1);
      step(); missResp = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checkOutput("stall_rden", missRden, 1'b1);
         checkOutput("stall_rd_addr", missAddr, 32'h0001_00E0);
         checkOutput("stall_rd_ready", reqReady, 1'b0);
         step();
      end
      missResp = 1;
      @(negedge clk); checkOutput("stall_rden_hs", missRden, 1'b1);
      step(); updValid = 1; updRdata = patA;
      @(negedge clk);
      step(); updValid = 0;
      @(negedge clk);
      checkOutput("stall_fill", fillValid, 1'b1);
      checkOutput("stall_fill_addr", fillAddr, 32'h0001_00E0);

      $display("[TB] flush in WAIT");
      step(); reqValid = 1; reqAddr = 32'h0000_3000; vicDirty = 0;
      @(negedge clk);
      step(); reqValid = 0;
      @(negedge clk);
      step(); flush = 1; updValid = 1;
      @(negedge clk);
      checkOutput("flush_wait_fill", fillValid, 1'b0);
      checkOutput("flush_wait_err", err, 1'b0);
      step(); flush = 0; updValid = 0; reqValid = 1; reqAddr = 32'h4444_5550;
      @(negedge clk);
      checkOutput("flush_no_fill", fillValid, 1'b0);
      checkOutput("flush_idle", busy, 1'b0);
      checkOutput("flush_reaccept", reqReady, 1'b1);
      step(); reqValid = 0;
      @(negedge clk);
      checkOutput("flush_new_rden", missRden, 1'b1);
      checkOutput("flush_new_addr", missAddr, 32'h4444_5540);
      step(); flush = 1;
      @(negedge clk); checkOutput("flush_rd_ready", reqReady, 1'b0);
      step(); flush = 0;
      @(negedge clk); checkOutput("flush_rd_idle", busy, 1'b0);

      $display("[TB] watchdog timeout");
      step(); reqValid = 1; reqAddr = 32'h0000_5000;
      @(negedge clk);
      step(); reqValid = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         step(); @(negedge clk);
         checkOutput("timeout_early_err", err, 1'b0);
      end
      step(); @(negedge clk);
      checkOutput("timeout_err", err, 1'b1);
      checkOutput("timeout_no_fill", fillValid, 1'b0);
      step(); updValid = 1; updRdata = patB;
      @(negedge clk);
      checkOutput("timeout_err_once", err, 1'b0);
      checkOutput("timeout_idle", busy, 1'b0);
      step(); updValid = 0;
      @(negedge clk);
      checkOutput("late_upd_fill", fillValid, 1'b0);
      checkOutput("late_upd_busy", busy, 1'b0);

      $display("[TB] flush in WB with response");
      step(); reqValid = 1; reqAddr = 32'h0000_6000; vicDirty = 1; vicAddr = 32'h0000_7000;
      @(negedge clk);
      step(); reqValid = 0; vicDirty = 0; flush = 1;
      @(negedge clk); checkOutput("wbflush_wren", missWren, 1'b1);
      step(); flush = 0;
      @(negedge clk);
      checkOutput("wbflush_idle", busy, 1'b0);
      checkOutput("wbflush_no_rden", missRden, 1'b0);

      $display("[TB] busy back-pressure");
      a0 = accepts;
      step(); reqValid = 1; reqAddr = 32'h0003_0010;
      @(negedge clk);
      step(); @(negedge clk); checkOutput("bp_rd_ready", reqReady, 1'b0);
      step(); updValid = 1; updRdata = patA;
      @(negedge clk); checkOutput("bp_wait_ready", reqReady, 1'b0);
      step(); updValid = 0;
      @(negedge clk);
      checkOutput("bp_fill", fillValid, 1'b1);
      checkOutput("bp_fill_ready", reqReady, 1'b0);
      step();
      checkOutput("bp_one_accept", 32'(accepts), 32'(a0 + 1));
      @(negedge clk); checkOutput("bp_second_ready", reqReady, 1'b1);
      step(); reqValid = 0;
      checkOutput("bp_two_accepts", 32'(accepts), 32'(a0 + 2));
      flush = 1;
      @(negedge clk);
      step(); flush = 0;
      @(negedge clk); checkOutput("bp_clear", busy, 1'b0);

      $display("[TB] random traffic");
      for (int c = 0; c < 4000; c++) begin
         step();
         applyStimulus();
      end
      step();
      reqValid = 0; flush = 0; updValid = 0; missResp = 0;
      repeat (3) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nano_cache_miss_ctrl.md
# nano_cache_miss_ctrl

Miss sequencer sitting directly upstream of the cache update stage in the NanoCore cache. It accepts one miss from the tag-lookup stage, writes back the dirty victim line if there is one, and issues the refill read. It then waits for the refilled 8-word line and presents it to the tag/data arrays as a single-cycle fill. It aborts cleanly on pipeline flush and on a refill watchdog timeout.

## Interface
Parameters:
- WAIT_MAX, 15: maximum cycles spent in WAIT before a timeout (1..255).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  pipeline flush; abort the current miss.
- i_req_valid  in  1  miss request from the lookup stage.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_addr  in  32  missing byte address.
- i_req_victim_dirty  in  1  the victim line must be written back.
- i_req_victim_addr  in  32  victim line address.
- i_req_victim_data  in  8x32  victim line data.
- o_miss_rden  out  1  refill read request to the update stage.
- o_miss_wren  out  1  writeback request to the update stage.
- o_miss_addr  out  32  line-aligned address.
- o_miss_wdata  out  8x32  writeback data.
- o_miss_wstrb  out  8x4  writeback strobes.
- i_miss_resp  in  1  update stage accepted rden/wren this cycle.
- i_upd_valid  in  1  refill data valid.
- i_upd_rdata  in  8x32  refill line.
- o_fill_valid  out  1  one-cycle line fill strobe to the arrays.
- o_fill_addr  out  32  line-aligned fill address.
- o_fill_data  out  8x32  fill line.
- o_busy  out  1  state != IDLE.
- o_err  out  1  one-cycle pulse on watchdog timeout.

## Operation
- States: IDLE, WB, RD, WAIT, FILL. Reset state is IDLE.
- o_req_ready = (state==IDLE) & ~i_flush.
- On accept:
  - Latch the request address, aligned to {addr[31:5],5'b0}.
  - Latch the victim fields.
  - Next state is WB if dirty, otherwise RD.
- WB:
  - o_miss_wren=1, o_miss_addr=aligned victim addr, o_miss_wdata=victim data, o_miss_wstrb=all 4'hF.
  - Hold until i_miss_resp, then go to RD.
- RD:
  - o_miss_rden=1, o_miss_addr=aligned request addr.
  - wstrb=0 in this state.
  - Hold until i_miss_resp, then go to WAIT and clear the watchdog counter.
- WAIT:
  - On i_upd_valid: latch i_upd_rdata, go to FILL.
  - Otherwise the counter increments.
  - When counter==WAIT_MAX-1 with no valid: pulse o_err and go to IDLE with no fill.
- FILL:
  - o_fill_valid=1 for exactly one cycle, with the latched address and data.
  - Then go to IDLE.
- Requests and strobes are combinational from state.
  - o_miss_wren and o_miss_rden are never high together.
  - Both are 0 outside WB and RD.
- i_upd_valid outside WAIT is ignored.
- Flush:
  - From any state, the next state is IDLE. No fill, no err, and the request is discarded.
  - Flush in WB with i_miss_resp high in the same cycle: the write counts as issued, and there is still no refill.
  - Flush has priority over i_upd_valid and over timeout in the same cycle.
- The counter width is clog2(WAIT_MAX+1) and saturates at WAIT_MAX.

## Timing
- Reset values:
  - All outputs are 0, except o_req_ready=1.
  - Latches and counter are 0.
- Accept in cycle T:
  - Clean miss: RD at T+1.
  - Dirty miss: WB at T+1, RD at T+2 (with immediate resp).
- WAIT is entered the cycle after the rden handshake. It must accept i_upd_valid from its first cycle, since a zero-buffer update stage returns data one cycle after rden.
- Fill strobe comes 1 cycle after i_upd_valid.
- Minimum accept-to-fill:
  - Clean: T+3 with BUFFER=0, T+4 with BUFFER=1.
  - Dirty: one cycle later.
- The next request can be accepted in the cycle after FILL. There is no back-to-back overlap.

## Test plan
- Clean miss:
  - Stimulus: addr 0x0000_1234, i_miss_resp tied high, data returns 2 cycles after rden.
  - Response: rden at T+1 with addr 0x0000_1220; fill at T+4 with matching data; o_busy low at T+5.
- Dirty miss:
  - Stimulus: victim addr 0x0000_8040, data words 0..7.
  - Response: wren at T+1 with wstrb all 0xF, then rden at T+2, then fill.
- Response stall:
  - Stimulus: i_miss_resp held low 3 cycles in WB and 2 cycles in RD.
  - Response: wren/rden and address stay stable throughout; the sequence completes; o_req_ready stays low.
- Flush mid-WAIT:
  - Stimulus: assert i_flush in the same cycle as i_upd_valid.
  - Response: no o_fill_valid; IDLE next cycle; a new request is accepted immediately.
- Timeout:
  - Stimulus: WAIT_MAX=4, no i_upd_valid.
  - Response: o_err pulses in the 4th WAIT cycle; return to IDLE; no fill; a late i_upd_valid is ignored.
- Busy back-pressure:
  - Stimulus: i_req_valid held high throughout a miss.
  - Response: exactly one accept per miss; second accept the cycle after FILL.
